ysyx_210544_regfile_sb: RTL and testbench

Parametrised integer register file with configurable read/write port counts, same-cycle write-to-read bypass and a per-register scoreboard of pending writes. It replaces the fixed 2R1W register file between decode and writeback. Issue marks a destination busy, writeback clears it, and read ports report hazards so the pipeline can stall. It also exports a flattened write-through register image for the difftest interface.

---
 rtl/ysyx_210544_regfile_sb.sv | 161 ++++++++++++++++
 tb/tb_ysyx_210544_regfile_sb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210544_regfile_sb.sv
// Parametrised integer register file with write-to-read bypass and a
// per-register scoreboard of pending writes (issue sets, writeback clears).

// One read port: indexes the bypassed register image and the scoreboard.
module ysyx_210544_regfile_sb_rd #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                            en,
  input  logic [AW-1:0]                   idx,
  input  logic [NREGS-1:0][XLEN-1:0]      img,
  input  logic [NREGS-1:0]                busy,
  input  logic [NREGS-1:0]                hit,
  output logic [XLEN-1:0]                 rd_data,
  output logic                            rd_busy
);

  // img already carries the same-cycle write, so only the enable gates it;
  // a write landing this cycle resolves the hazard for its consumer.
  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (en) begin
      rd_data = img[idx];
      rd_busy = busy[idx] & ~hit[idx];
    end
  end

endmodule

module ysyx_210544_regfile_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NR    = 2,
  parameter int NW    = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NR*AW-1:0]        i_rs_idx,
  input  logic [NR-1:0]           i_rs_ren,
  output logic [NR*XLEN-1:0]      o_rs_data,
  output logic [NR-1:0]           o_rs_busy,
  input  logic [NW*AW-1:0]        i_wr_idx,
  input  logic [NW-1:0]           i_wr_wen,
  input  logic [NW*XLEN-1:0]      i_wr_data,
  input  logic                    i_iss_valid,
  input  logic [AW-1:0]           i_iss_rd,
  input  logic                    i_flush,
  output logic [AW:0]             o_busy_cnt,
  output logic [NREGS*XLEN-1:0]   o_regs
);

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
  } wr_req_t;

  wr_req_t [NW-1:0]               wr;
  logic [NREGS-1:0][XLEN-1:0]     regs;
  logic [NREGS-1:0]               busy;
  logic [NREGS-1:0]               busy_nxt;
  logic [NREGS-1:0]               wr_hit;
  logic [NREGS-1:0][XLEN-1:0]     wr_val;
  logic [NREGS-1:0][XLEN-1:0]     img;
  logic [AW:0]                    cnt_nxt;

  for (genvar p = 0; p < NW; p++) begin : g_wr
    assign wr[p].en   = i_wr_wen[p];
    assign wr[p].idx  = i_wr_idx[p*AW +: AW];
    assign wr[p].data = i_wr_data[p*XLEN +: XLEN];
  end

  // Per-register write decode; ascending port scan lets the highest port win.
  // Register 0 never sees a hit, which keeps it pinned at zero.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < NW; p++) begin
        if (wr[p].en && wr[p].idx == AW'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr[p].data;
        end
      end
    end
  end

  // Write-through image shared by the read ports and difftest; zero in reset.
  always_comb begin
    img = '0;
    if (rst_n) begin
      for (int r = 0; r < NREGS; r++)
        img[r] = wr_hit[r] ? wr_val[r] : regs[r];
    end
  end

  assign o_regs = img;

  // Storage update; regs[0] is only ever loaded by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++)
        if (wr_hit[r]) regs[r] <= wr_val[r];
    end
  end

  // Scoreboard next state: flush > issue (younger producer) > writeback > hold.
  always_comb begin
    busy_nxt = busy;
    if (i_flush) begin
      busy_nxt = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (i_iss_valid && i_iss_rd == AW'(r)) busy_nxt[r] = 1'b1;
        else if (wr_hit[r])                    busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the post-update scoreboard; bit 0 is excluded so it tops out
  // at NREGS-1.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < NREGS; r++)
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
  end

  // Scoreboard and busy-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      o_busy_cnt <= '0;
    end else begin
      busy       <= busy_nxt;
      o_busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    ysyx_210544_regfile_sb_rd #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_rd (
      .en     (i_rs_ren[k] & rst_n),
      .idx    (i_rs_idx[k*AW +: AW]),
      .img    (img),
      .busy   (busy),
      .hit    (wr_hit),
      .rd_data(o_rs_data[k*XLEN +: XLEN]),
      .rd_busy(o_rs_busy[k])
    );
  end

endmodule

// File: tb/tb_ysyx_210544_regfile_sb.sv
// Directed bench: one table row per cycle, plus hand sequences for read
// enable gating and busy-count saturation.
module tb_ysyx_210544_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int AW    = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NR*AW-1:0]      rs_idx;
  logic [NR-1:0]         rs_ren;
  logic [NR*XLEN-1:0]    rs_data;
  logic [NR-1:0]         rs_busy;
  logic [NW*AW-1:0]      wr_idx;
  logic [NW-1:0]         wr_wen;
  logic [NW*XLEN-1:0]    wr_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_rd;
  logic                  flush;
  logic [AW:0]           busy_cnt;
  logic [NREGS*XLEN-1:0] regs_img;

  int total = 0;
  int bad   = 0;

  ysyx_210544_regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rs_idx   (rs_idx),
    .i_rs_ren   (rs_ren),
    .o_rs_data  (rs_data),
    .o_rs_busy  (rs_busy),
    .i_wr_idx   (wr_idx),
    .i_wr_wen   (wr_wen),
    .i_wr_data  (wr_data),
    .i_iss_valid(iss_valid),
    .i_iss_rd   (iss_rd),
    .i_flush    (flush),
    .o_busy_cnt (busy_cnt),
    .o_regs     (regs_img)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            rst;
    logic            we0; logic [AW-1:0] wi0; logic [XLEN-1:0] wd0;
    logic            we1; logic [AW-1:0] wi1; logic [XLEN-1:0] wd1;
    logic            iss; logic [AW-1:0] ird;
    logic            fl;
    logic [AW-1:0]   r0;  logic [AW-1:0]   r1;
    logic [XLEN-1:0] ed0; logic            eb0;
    logic [XLEN-1:0] ed1; logic            eb1;
    logic [AW:0]     ecnt;
    logic [AW-1:0]   ri;  logic [XLEN-1:0] erv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst,
                     input logic we0, input int wi0, input logic [XLEN-1:0] wd0,
                     input logic we1, input int wi1, input logic [XLEN-1:0] wd1,
                     input logic iss, input int ird, input logic fl,
                     input int r0, input int r1,
                     input logic [XLEN-1:0] ed0, input logic eb0,
                     input logic [XLEN-1:0] ed1, input logic eb1,
                     input int ecnt, input int ri, input logic [XLEN-1:0] erv);
    vec_t v;
    v.rst = rst;
    v.we0 = we0; v.wi0 = AW'(wi0); v.wd0 = wd0;
    v.we1 = we1; v.wi1 = AW'(wi1); v.wd1 = wd1;
    v.iss = iss; v.ird = AW'(ird); v.fl = fl;
    v.r0 = AW'(r0); v.r1 = AW'(r1);
    v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1;
    v.ecnt = (AW+1)'(ecnt); v.ri = AW'(ri); v.erv = erv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; rs_ren = '1; rs_idx = '0; wr_wen = '0; wr_idx = '0;
    wr_data = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    //   rst we0 wi0 wd0            we1 wi1 wd1    iss ird fl  r0 r1  ed0           eb0 ed1           eb1 cnt ri erv
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   5,5,  64'h0,        0, 64'h0,        0,  0, 5,64'h0);
    add(1, 1,5,64'hDEAD_BEEF,       0,0,64'h0,     0,0, 0,   5,5,  64'hDEADBEEF, 0, 64'hDEADBEEF, 0,  0, 5,64'hDEADBEEF);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   5,5,  64'hDEADBEEF, 0, 64'hDEADBEEF, 0,  0, 5,64'hDEADBEEF);
    add(1, 1,0,64'h1234,            0,0,64'h0,     1,0, 0,   0,0,  64'h0,        0, 64'h0,        0,  0, 0,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   0,5,  64'h0,        0, 64'hDEADBEEF, 0,  0, 0,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     1,7, 0,   7,7,  64'h0,        0, 64'h0,        0,  0, 7,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   7,5,  64'h0,        1, 64'hDEADBEEF, 0,  1, 7,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   7,7,  64'h0,        1, 64'h0,        1,  1, 7,64'h0);
    add(1, 1,7,64'h55,              0,0,64'h0,     0,0, 0,   7,7,  64'h55,       0, 64'h55,       0,  1, 7,64'h55);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   7,7,  64'h55,       0, 64'h55,       0,  0, 7,64'h55);
    add(1, 1,3,64'hAA,              1,3,64'hBB,    0,0, 0,   3,3,  64'hBB,       0, 64'hBB,       0,  0, 3,64'hBB);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   3,3,  64'hBB,       0, 64'hBB,       0,  0, 3,64'hBB);
    add(1, 1,9,64'h1,               0,0,64'h0,     1,9, 0,   9,9,  64'h1,        0, 64'h1,        0,  0, 9,64'h1);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   9,9,  64'h1,        1, 64'h1,        1,  1, 9,64'h1);
    add(1, 0,0,64'h0,               0,0,64'h0,     1,1, 0,   9,1,  64'h1,        1, 64'h0,        0,  1, 1,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     1,2, 0,   1,2,  64'h0,        1, 64'h0,        0,  2, 2,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     1,3, 0,   2,3,  64'h0,        1, 64'hBB,       0,  3, 3,64'hBB);
    add(1, 0,0,64'h0,               0,0,64'h0,     1,4, 0,   3,4,  64'hBB,       1, 64'h0,        0,  4, 4,64'h0);
    add(1, 1,2,64'h22,              0,0,64'h0,     1,6, 1,   4,2,  64'h0,        1, 64'h22,       0,  5, 2,64'h22);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   6,4,  64'h0,        0, 64'h0,        0,  0, 2,64'h22);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   9,2,  64'h1,        0, 64'h22,       0,  0, 9,64'h1);
    add(1, 1,2,64'h33,              0,0,64'h0,     1,2, 0,   2,2,  64'h33,       0, 64'h33,       0,  0, 2,64'h33);
    add(0, 1,5,64'h99,              1,6,64'h66,    1,5, 0,   2,5,  64'h0,        0, 64'h0,        0,  1, 3,64'h0);
    add(1, 0,0,64'h0,               0,0,64'h0,     0,0, 0,   2,5,  64'h0,        0, 64'h0,        0,  0, 2,64'h0);
    add(1, 0,0,64'h0,               1,8,64'hC0DE,  0,0, 0,   8,3,  64'hC0DE,     0, 64'h0,        0,  0, 8,64'hC0DE);

    foreach (vecs[i]) begin
      @(negedge clk);
      idle();
      rst_n     = vecs[i].rst;
      wr_wen    = {vecs[i].we1, vecs[i].we0};
      wr_idx    = {vecs[i].wi1, vecs[i].wi0};
      wr_data   = {vecs[i].wd1, vecs[i].wd0};
      iss_valid = vecs[i].iss;
      iss_rd    = vecs[i].ird;
      flush     = vecs[i].fl;
      rs_idx    = {vecs[i].r1, vecs[i].r0};
      #1;
      chk($sformatf("v%0d d0", i),   rs_data[0 +: XLEN],    vecs[i].ed0);
      chk($sformatf("v%0d b0", i),   XLEN'(rs_busy[0]),     XLEN'(vecs[i].eb0));
      chk($sformatf("v%0d d1", i),   rs_data[XLEN +: XLEN], vecs[i].ed1);
      chk($sformatf("v%0d b1", i),   XLEN'(rs_busy[1]),     XLEN'(vecs[i].eb1));
      chk($sformatf("v%0d cnt", i),  XLEN'(busy_cnt),       XLEN'(vecs[i].ecnt));
      chk($sformatf("v%0d oregs", i), regs_img[int'(vecs[i].ri)*XLEN +: XLEN], vecs[i].erv);
    end

    // Read enable gates both data and hazard of a busy, non-zero register.
    @(negedge clk); idle(); wr_wen = 2'b01; wr_idx = {5'd0, 5'd10}; wr_data = {64'h0, 64'hF00D};
    @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = 5'd10;
    @(negedge clk); idle(); rs_idx = {5'd10, 5'd10}; rs_ren = 2'b10; #1;
    chk("ren0 data", rs_data[0 +: XLEN], 64'h0);
    chk("ren0 busy", XLEN'(rs_busy[0]), 64'h0);
    chk("ren1 data", rs_data[XLEN +: XLEN], 64'hF00D);
    chk("ren1 busy", XLEN'(rs_busy[1]), 64'h1);

    // Fill the scoreboard completely; count saturates at NREGS-1 and rd=0
    // issue adds nothing.
    for (int r = 1; r < NREGS; r++) begin
      @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = AW'(r);
    end
    @(negedge clk); idle(); iss_valid = 1'b1; iss_rd = 5'd0; #1;
    chk("full cnt", XLEN'(busy_cnt), 64'd31);
    @(negedge clk); idle(); rs_idx = {5'd0, 5'd31}; #1;
    chk("full cnt rd0", XLEN'(busy_cnt), 64'd31);
    chk("x31 busy", XLEN'(rs_busy[0]), 64'h1);
    chk("x0 busy", XLEN'(rs_busy[1]), 64'h0);
    flush = 1'b1;
    @(negedge clk); idle(); rs_idx = {5'd1, 5'd31}; #1;
    chk("flush cnt", XLEN'(busy_cnt), 64'd0);
    chk("flush b0", XLEN'(rs_busy[0]), 64'h0);
    chk("flush b1", XLEN'(rs_busy[1]), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
